// File: rtl/hms_counter_if.sv
// Load request and time-of-day bundle between the timekeeping core and its
// controller/display side.
interface hms_counter_if;
    logic       load;
    logic [4:0] load_hour;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       sec_tick;
    logic       day_wrap;
    logic       load_err;
    logic       stalled;

    modport master (
        output load, load_hour, load_min, load_sec,
        input  hour, min, sec, sec_tick, day_wrap, load_err, stalled
    );

    modport slave (
        input  load, load_hour, load_min, load_sec,
        output hour, min, sec, sec_tick, day_wrap, load_err, stalled
    );
endinterface

// File: rtl/hms_counter.sv
// Time-of-day core: counts hours/minutes/seconds from the 1 Hz blink wave,
// accepts validated time loads and flags a missing time base.
module hms_counter #(
    parameter int STALL_MAX = 150000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          blink_in,
    hms_counter_if.slave  bus
);
    localparam int             CW          = $clog2(STALL_MAX + 1);
    localparam logic [CW-1:0]  STALL_MAX_C = CW'(STALL_MAX);
    localparam logic [CW-1:0]  CNT_ONE_C   = CW'(1);

    logic          sync1_r, sync2_r, prev_r;
    logic [4:0]    hour_r;
    logic [5:0]    min_r, sec_r;
    logic          sec_tick_r, day_wrap_r, load_err_r, stalled_r;
    logic [CW-1:0] stall_cnt_r;

    logic          rise_s, load_ok_s;
    logic [4:0]    hour_nx_s;
    logic [5:0]    min_nx_s, sec_nx_s;
    logic          tick_nx_s, wrap_nx_s, err_nx_s;
    logic [CW-1:0] stall_cnt_nx_s;

    assign rise_s    = sync2_r & ~prev_r;
    assign load_ok_s = (bus.load_hour <= 5'd23) && (bus.load_min <= 6'd59) &&
                       (bus.load_sec <= 6'd59);

    // Next time value: a valid load wins over a coincident rise; a rejected
    // load only raises load_err and lets the rise advance the clock.
    always_comb begin
        hour_nx_s = hour_r;
        min_nx_s  = min_r;
        sec_nx_s  = sec_r;
        tick_nx_s = 1'b0;
        wrap_nx_s = 1'b0;
        err_nx_s  = 1'b0;
        if (bus.load && load_ok_s) begin
            hour_nx_s = bus.load_hour;
            min_nx_s  = bus.load_min;
            sec_nx_s  = bus.load_sec;
        end else begin
            err_nx_s = bus.load;
            if (rise_s) begin
                tick_nx_s = 1'b1;
                if (sec_r == 6'd59) begin
                    sec_nx_s = 6'd0;
                    if (min_r == 6'd59) begin
                        min_nx_s = 6'd0;
                        if (hour_r == 5'd23) begin
                            hour_nx_s = 5'd0;
                            wrap_nx_s = 1'b1;
                        end else begin
                            hour_nx_s = hour_r + 5'd1;
                        end
                    end else begin
                        min_nx_s = min_r + 6'd1;
                    end
                end else begin
                    sec_nx_s = sec_r + 6'd1;
                end
            end else begin
                tick_nx_s = 1'b0;
            end
        end
    end

    // Stall counter: cleared by every rise, saturates at STALL_MAX.
    always_comb begin
        stall_cnt_nx_s = stall_cnt_r;
        if (rise_s) begin
            stall_cnt_nx_s = '0;
        end else if (stall_cnt_r != STALL_MAX_C) begin
            stall_cnt_nx_s = stall_cnt_r + CNT_ONE_C;
        end else begin
            stall_cnt_nx_s = stall_cnt_r;
        end
    end

    // Input synchronizer and edge-history flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= blink_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Time registers, status pulses and stall monitor.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hour_r      <= 5'd0;
            min_r       <= 6'd0;
            sec_r       <= 6'd0;
            sec_tick_r  <= 1'b0;
            day_wrap_r  <= 1'b0;
            load_err_r  <= 1'b0;
            stall_cnt_r <= '0;
            stalled_r   <= 1'b0;
        end else begin
            hour_r      <= hour_nx_s;
            min_r       <= min_nx_s;
            sec_r       <= sec_nx_s;
            sec_tick_r  <= tick_nx_s;
            day_wrap_r  <= wrap_nx_s;
            load_err_r  <= err_nx_s;
            stall_cnt_r <= stall_cnt_nx_s;
            // Compare the next count so stalled rises exactly STALL_MAX edges after the last rise.
            stalled_r   <= (stall_cnt_nx_s == STALL_MAX_C);
        end
    end

    assign bus.hour     = hour_r;
    assign bus.min      = min_r;
    assign bus.sec      = sec_r;
    assign bus.sec_tick = sec_tick_r;
    assign bus.day_wrap = day_wrap_r;
    assign bus.load_err = load_err_r;
    assign bus.stalled  = stalled_r;
endmodule

// File: tb/tb_hms_counter.sv
// Directed self-checking bench for hms_counter with a short stall limit.
module tb_hms_counter;
    logic clk = 1'b0;
    logic reset;
    logic blink_in;
    int   n_checks = 0;
    int   n_fail   = 0;

    hms_counter_if bus ();

    hms_counter #(.STALL_MAX(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .blink_in (blink_in),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        bus.load = 1'b1; bus.load_hour = h; bus.load_min = m; bus.load_sec = s;
        step();
        bus.load = 1'b0;
    endtask

    // One blink rising edge; captures the pulses seen right after the advance edge.
    task automatic pulse(output logic t_o, output logic w_o);
        blink_in = 1'b1;
        step(); step(); step();
        t_o = bus.sec_tick;
        w_o = bus.day_wrap;
        blink_in = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_reset();
        reset = 1'b0; blink_in = 1'b0;
        bus.load = 1'b0; bus.load_hour = 5'd0; bus.load_min = 6'd0; bus.load_sec = 6'd0;
        step(); step();
        reset = 1'b1;
        step();
        n_checks++;
        if ({bus.hour, bus.min, bus.sec} !== 17'd0) begin
            n_fail++; $display("FAIL reset_time: got %0d:%0d:%0d expected 0:0:0", bus.hour, bus.min, bus.sec);
        end
        n_checks++;
        if ({bus.sec_tick, bus.day_wrap, bus.load_err, bus.stalled} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {bus.sec_tick, bus.day_wrap, bus.load_err, bus.stalled});
        end
    endtask

    task automatic test_latency();
        int ticks = 0;
        blink_in = 1'b1;
        step(); // edge N
        n_checks++;
        if (bus.sec !== 6'd0 || bus.sec_tick !== 1'b0) begin
            n_fail++; $display("FAIL latency_N: got sec=%0d tick=%b expected sec=0 tick=0", bus.sec, bus.sec_tick);
        end
        step(); // edge N+1
        n_checks++;
        if (bus.sec !== 6'd0 || bus.sec_tick !== 1'b0) begin
            n_fail++; $display("FAIL latency_N1: got sec=%0d tick=%b expected sec=0 tick=0", bus.sec, bus.sec_tick);
        end
        step(); // edge N+2
        n_checks++;
        if (bus.sec !== 6'd1 || bus.sec_tick !== 1'b1) begin
            n_fail++; $display("FAIL latency_N2: got sec=%0d tick=%b expected sec=1 tick=1", bus.sec, bus.sec_tick);
        end
        step(); // edge N+3
        n_checks++;
        if (bus.sec !== 6'd1 || bus.sec_tick !== 1'b0) begin
            n_fail++; $display("FAIL latency_N3: got sec=%0d tick=%b expected sec=1 tick=0", bus.sec, bus.sec_tick);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.sec_tick === 1'b1) ticks++;
        end
        blink_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.sec_tick === 1'b1) ticks++;
        end
        n_checks++;
        if (ticks !== 0 || bus.sec !== 6'd1) begin
            n_fail++; $display("FAIL latency_hold_fall: got ticks=%0d sec=%0d expected ticks=0 sec=1", ticks, bus.sec);
        end
    endtask

    task automatic test_rollover();
        logic t, w;
        do_load(5'd23, 6'd59, 6'd59);
        n_checks++;
        if ({bus.hour, bus.min, bus.sec} !== {5'd23, 6'd59, 6'd59}) begin
            n_fail++; $display("FAIL load_23_59_59: got %0d:%0d:%0d expected 23:59:59", bus.hour, bus.min, bus.sec);
        end
        pulse(t, w);
        n_checks++;
        if ({bus.hour, bus.min, bus.sec} !== 17'd0 || t !== 1'b1 || w !== 1'b1) begin
            n_fail++; $display("FAIL day_wrap: got %0d:%0d:%0d tick=%b wrap=%b expected 0:0:0 tick=1 wrap=1", bus.hour, bus.min, bus.sec, t, w);
        end
        do_load(5'd10, 6'd59, 6'd59);
        pulse(t, w);
        n_checks++;
        if ({bus.hour, bus.min, bus.sec} !== {5'd11, 6'd0, 6'd0} || t !== 1'b1 || w !== 1'b0) begin
            n_fail++; $display("FAIL hour_roll: got %0d:%0d:%0d tick=%b wrap=%b expected 11:0:0 tick=1 wrap=0", bus.hour, bus.min, bus.sec, t, w);
        end
        do_load(5'd3, 6'd4, 6'd58);
        pulse(t, w);
        n_checks++;
        if ({bus.hour, bus.min, bus.sec} !== {5'd3, 6'd4, 6'd59} || w !== 1'b0) begin
            n_fail++; $display("FAIL sec_plain: got %0d:%0d:%0d wrap=%b expected 3:4:59 wrap=0", bus.hour, bus.min, bus.sec, w);
        end
    endtask

    task automatic test_invalid_load();
        logic [4:0] bad_h [3] = '{5'd24, 5'd12, 5'd0};
        logic [5:0] bad_m [3] = '{6'd0, 6'd60, 6'd0};
        logic [5:0] bad_s [3] = '{6'd0, 6'd0, 6'd63};
        do_load(5'd5, 6'd6, 6'd7);
        for (int i = 0; i < 3; i++) begin
            do_load(bad_h[i], bad_m[i], bad_s[i]);
            n_checks++;
            if ({bus.hour, bus.min, bus.sec} !== {5'd5, 6'd6, 6'd7} || bus.load_err !== 1'b1) begin
                n_fail++; $display("FAIL invalid_load_%0d: got %0d:%0d:%0d err=%b expected 5:6:7 err=1", i, bus.hour, bus.min, bus.sec, bus.load_err);
            end
            step();
            n_checks++;
            if (bus.load_err !== 1'b0) begin
                n_fail++; $display("FAIL load_err_width_%0d: got %b expected 0", i, bus.load_err);
            end
        end
    endtask

    task automatic test_collision();
        blink_in = 1'b1;
        step(); step();
        do_load(5'd8, 6'd0, 6'd0);
        n_checks++;
        if ({bus.hour, bus.min, bus.sec} !== {5'd8, 6'd0, 6'd0} || bus.sec_tick !== 1'b0) begin
            n_fail++; $display("FAIL collide_valid: got %0d:%0d:%0d tick=%b expected 8:0:0 tick=0", bus.hour, bus.min, bus.sec, bus.sec_tick);
        end
        blink_in = 1'b0;
        step(); step(); step();
        n_checks++;
        if ({bus.hour, bus.min, bus.sec} !== {5'd8, 6'd0, 6'd0}) begin
            n_fail++; $display("FAIL collide_discard: got %0d:%0d:%0d expected 8:0:0", bus.hour, bus.min, bus.sec);
        end
        blink_in = 1'b1;
        step(); step();
        do_load(5'd24, 6'd0, 6'd0);
        n_checks++;
        if ({bus.hour, bus.min, bus.sec} !== {5'd8, 6'd0, 6'd1} || bus.sec_tick !== 1'b1 || bus.load_err !== 1'b1) begin
            n_fail++; $display("FAIL collide_invalid: got %0d:%0d:%0d tick=%b err=%b expected 8:0:1 tick=1 err=1", bus.hour, bus.min, bus.sec, bus.sec_tick, bus.load_err);
        end
        blink_in = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_stall();
        logic [5:0] s0;
        blink_in = 1'b1;
        step(); step(); step(); // last rise sampled here
        blink_in = 1'b0;
        s0 = bus.sec;
        for (int i = 0; i < 9; i++) step();
        n_checks++;
        if (bus.stalled !== 1'b0) begin
            n_fail++; $display("FAIL stall_early: got %b expected 0 after 9 cycles", bus.stalled);
        end
        step();
        n_checks++;
        if (bus.stalled !== 1'b1) begin
            n_fail++; $display("FAIL stall_at_max: got %b expected 1 after 10 cycles", bus.stalled);
        end
        step(); step(); step();
        n_checks++;
        if (bus.stalled !== 1'b1 || bus.sec !== s0) begin
            n_fail++; $display("FAIL stall_hold: got stalled=%b sec=%0d expected stalled=1 sec=%0d", bus.stalled, bus.sec, s0);
        end
        blink_in = 1'b1;
        step(); step();
        n_checks++;
        if (bus.stalled !== 1'b1) begin
            n_fail++; $display("FAIL stall_before_rise: got %b expected 1", bus.stalled);
        end
        step();
        n_checks++;
        if (bus.stalled !== 1'b0 || bus.sec_tick !== 1'b1 || bus.sec !== s0 + 6'd1) begin
            n_fail++; $display("FAIL stall_recover: got stalled=%b tick=%b sec=%0d expected 0 1 %0d", bus.stalled, bus.sec_tick, bus.sec, s0 + 6'd1);
        end
        blink_in = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_reset_async();
        do_load(5'd12, 6'd34, 6'd56);
        for (int i = 0; i < 11; i++) step();
        n_checks++;
        if ({bus.hour, bus.min, bus.sec} !== {5'd12, 6'd34, 6'd56} || bus.stalled !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset: got %0d:%0d:%0d stalled=%b expected 12:34:56 stalled=1", bus.hour, bus.min, bus.sec, bus.stalled);
        end
        blink_in = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.hour, bus.min, bus.sec} !== 17'd0 || {bus.sec_tick, bus.day_wrap, bus.load_err, bus.stalled} !== 4'b0000) begin
            n_fail++; $display("FAIL async_reset: got %0d:%0d:%0d flags=%b expected 0:0:0 0000", bus.hour, bus.min, bus.sec, {bus.sec_tick, bus.day_wrap, bus.load_err, bus.stalled});
        end
        step(); step();
        n_checks++;
        if ({bus.hour, bus.min, bus.sec} !== 17'd0 || bus.sec_tick !== 1'b0) begin
            n_fail++; $display("FAIL reset_held: got %0d:%0d:%0d tick=%b expected 0:0:0 tick=0", bus.hour, bus.min, bus.sec, bus.sec_tick);
        end
        reset = 1'b1;
        step(); step();
        n_checks++;
        if (bus.sec !== 6'd0) begin
            n_fail++; $display("FAIL release_early: got sec=%0d expected 0", bus.sec);
        end
        step();
        n_checks++;
        if (bus.sec !== 6'd1 || bus.sec_tick !== 1'b1) begin
            n_fail++; $display("FAIL release_rise: got sec=%0d tick=%b expected sec=1 tick=1", bus.sec, bus.sec_tick);
        end
        blink_in = 1'b0;
        step(); step(); step();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_rollover();
        test_invalid_load();
        test_collision();
        test_stall();
        test_reset_async();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
